// File: rtl/spi_frame_ctrl.sv
// Frame sequencer: turns one register request into a 3-byte SPI frame
// driven through a byte-level master, with per-device frame chip-select.
module spi_frame_ctrl #(
    parameter int NUM_CS       = 4,
    parameter int CS_SEL_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
    parameter int CS_SETUP_CYC = 4,
    parameter int CS_HOLD_CYC  = 4,
    parameter int CS_IDLE_CYC  = 8,
    parameter int TIMEOUT_CYC  = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_rw,
    input  logic [14:0]         req_addr,
    input  logic [7:0]          req_wdata,
    input  logic [CS_SEL_W-1:0] req_cs_sel,
    output logic                rsp_valid,
    output logic [7:0]          rsp_rdata,
    output logic                rsp_err,
    output logic                busy,
    output logic                spi_trig,
    output logic [7:0]          spi_writedata,
    input  logic                spi_finish,
    input  logic [7:0]          spi_readdata,
    output logic [NUM_CS-1:0]   frame_cs_n
);

    localparam int M1 = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
    localparam int M2 = (M1 > CS_IDLE_CYC) ? M1 : CS_IDLE_CYC;
    localparam int M3 = (M2 > TIMEOUT_CYC) ? M2 : TIMEOUT_CYC;
    localparam int CNT_W = $clog2(M3 + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_TRIG,
        S_WAIT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            idx_q, idx_d;
    logic                  rw_q, rw_d;
    logic [14:0]           addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [7:0]            rd_q, rd_d;
    logic                  req_ready_q, req_ready_d;
    logic                  busy_q, busy_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [7:0]            rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  spi_trig_q, spi_trig_d;
    logic [7:0]            spi_wd_q, spi_wd_d;
    logic [NUM_CS-1:0]     cs_n_q, cs_n_d;

    function automatic logic [7:0] frame_byte(
        input logic [1:0]  i,
        input logic        rw,
        input logic [14:0] a,
        input logic [7:0]  wd
    );
        logic [7:0] b;
        case (i)
            2'd0:    b = {rw, a[14:8]};
            2'd1:    b = a[7:0];
            default: b = rw ? 8'h00 : wd;
        endcase
        return b;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        rd_d        = rd_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        spi_trig_d  = 1'b0;
        spi_wd_d    = spi_wd_q;
        cs_n_d      = cs_n_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    rw_d               = req_rw;
                    addr_d             = req_addr;
                    wdata_d            = req_wdata;
                    idx_d              = 2'd0;
                    err_d              = 1'b0;
                    rd_d               = 8'h00;
                    cnt_d              = CNT_W'(CS_SETUP_CYC - 1);
                    cs_n_d             = '1;
                    cs_n_d[req_cs_sel] = 1'b0;
                    state_d            = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    spi_trig_d = 1'b1;
                    spi_wd_d   = frame_byte(2'd0, rw_q, addr_q, wdata_q);
                    state_d    = S_TRIG;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_TRIG: begin
                cnt_d   = CNT_W'(TIMEOUT_CYC - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A finish on the last timeout cycle still counts as success.
                if (spi_finish) begin
                    if (idx_q == 2'd2) begin
                        if (rw_q) rd_d = spi_readdata;
                        cnt_d   = CNT_W'(CS_HOLD_CYC - 1);
                        state_d = S_HOLD;
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        spi_trig_d = 1'b1;
                        spi_wd_d   = frame_byte(idx_q + 2'd1, rw_q, addr_q, wdata_q);
                        state_d    = S_TRIG;
                    end
                end else if (cnt_q == '0) begin
                    err_d   = 1'b1;
                    cnt_d   = CNT_W'(CS_HOLD_CYC - 1);
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    cs_n_d      = '1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q;
                    rsp_rdata_d = (rw_q && !err_q) ? rd_q : 8'h00;
                    cnt_d       = CNT_W'(CS_IDLE_CYC);
                    state_d     = S_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready_d = (state_d == S_IDLE);
    assign busy_d      = (state_d != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            rd_q        <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            spi_trig_q  <= 1'b0;
            spi_wd_q    <= '0;
            cs_n_q      <= '1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            rd_q        <= rd_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            spi_trig_q  <= spi_trig_d;
            spi_wd_q    <= spi_wd_d;
            cs_n_q      <= cs_n_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign busy          = busy_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;
    assign spi_trig      = spi_trig_q;
    assign spi_writedata = spi_wd_q;
    assign frame_cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Bench for spi_frame_ctrl: behavioural byte master, event monitor and
// a frame-rule reference model checked with immediate assertions.
module tb_spi_frame_ctrl;

    localparam int S  = 4;
    localparam int H  = 4;
    localparam int I  = 8;
    localparam int TO = 4096;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rw = 1'b0;
    logic [14:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic [1:0] req_cs_sel = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic       spi_trig;
    logic [7:0] spi_writedata;
    logic       spi_finish = 1'b0;
    logic [7:0] spi_readdata = '0;
    logic [3:0] frame_cs_n;

    spi_frame_ctrl #(
        .NUM_CS(4), .CS_SEL_W(2), .CS_SETUP_CYC(S), .CS_HOLD_CYC(H),
        .CS_IDLE_CYC(I), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_cs_sel(req_cs_sel),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .spi_trig(spi_trig), .spi_writedata(spi_writedata),
        .spi_finish(spi_finish), .spi_readdata(spi_readdata),
        .frame_cs_n(frame_cs_n)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // byte-master behaviour, set by the main sequence
    int         cfg_f [3] = '{2, 2, 2};
    int         cfg_drop = -1;
    logic [7:0] cfg_rd = 8'h00;
    int         stray_cnt = 0;

    // monitor records
    logic [7:0] trig_q [$];
    int         trig_cyc_q [$];
    int         fin_cyc_q [$];
    int         acc_q [$];
    int         rsp_cyc_q [$];
    logic [7:0] rsp_rd_q [$];
    logic       rsp_er_q [$];
    int         fall_cyc_q [$];
    logic [3:0] fall_val_q [$];
    int         rise_cyc_q [$];
    int         bad_cs = 0;
    int         rdy_in_frame = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        logic [3:0] prev_cs;
        prev_cs = 4'hF;
        forever begin
            @(negedge clk);
            if (spi_trig === 1'b1) begin
                trig_q.push_back(spi_writedata);
                trig_cyc_q.push_back(cyc);
            end
            if (spi_finish === 1'b1) fin_cyc_q.push_back(cyc);
            if (req_valid && req_ready === 1'b1) acc_q.push_back(cyc);
            if (rsp_valid === 1'b1) begin
                rsp_cyc_q.push_back(cyc);
                rsp_rd_q.push_back(rsp_rdata);
                rsp_er_q.push_back(rsp_err);
            end
            if (prev_cs === 4'hF && frame_cs_n !== 4'hF) begin
                fall_cyc_q.push_back(cyc);
                fall_val_q.push_back(frame_cs_n);
            end
            if (prev_cs !== 4'hF && frame_cs_n === 4'hF) rise_cyc_q.push_back(cyc);
            if ($countones(~frame_cs_n) > 1) bad_cs++;
            if (req_ready === 1'b1 && frame_cs_n !== 4'hF) rdy_in_frame++;
            prev_cs = frame_cs_n;
        end
    end

    // byte master: finish F cycles after trig, or never on the dropped byte
    initial begin
        int bidx;
        int k;
        int stray_done;
        bidx = 0;
        stray_done = 0;
        forever begin
            @(posedge clk);
            #1;
            if (frame_cs_n === 4'hF) bidx = 0;
            if (stray_cnt != stray_done) begin
                stray_done++;
                spi_finish   = 1'b1;
                spi_readdata = 8'hEE;
                @(posedge clk);
                #1;
                spi_finish   = 1'b0;
                spi_readdata = 8'h00;
            end
            while (spi_trig === 1'b1) begin
                k = bidx;
                bidx++;
                if (k > 2 || k == cfg_drop) break;
                repeat (cfg_f[k]) @(posedge clk);
                #1;
                spi_finish   = 1'b1;
                spi_readdata = (k == 2) ? cfg_rd : 8'($urandom);
                @(posedge clk);
                #1;
                spi_finish   = 1'b0;
                spi_readdata = 8'h00;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic rw, input logic [14:0] a,
                                            input logic [7:0] wd, input int k);
        if (k == 0) return {rw, a[14:8]};
        if (k == 1) return a[7:0];
        return rw ? 8'h00 : wd;
    endfunction

    task automatic run_txn(input string tag, input logic rw, input logic [14:0] a,
                           input logic [7:0] wd, input logic [1:0] sel,
                           input logic [7:0] rd, input int f0, input int f1,
                           input int f2, input int drop);
        int bt, bf, ba, br, bfl, bri, nb, lat, to;
        logic [3:0] exp_cs;
        logic [7:0] exp_rd;
        cfg_f[0] = f0;
        cfg_f[1] = f1;
        cfg_f[2] = f2;
        cfg_drop = drop;
        cfg_rd   = rd;
        bt  = trig_q.size();
        bf  = fin_cyc_q.size();
        ba  = acc_q.size();
        br  = rsp_cyc_q.size();
        bfl = fall_cyc_q.size();
        bri = rise_cyc_q.size();
        exp_cs      = 4'hF;
        exp_cs[sel] = 1'b0;
        nb     = (drop >= 0) ? drop + 1 : 3;
        exp_rd = (rw && drop < 0) ? rd : 8'h00;
        lat = 1 + S + H;
        for (int k = 0; k < nb; k++) lat += 1 + ((k == drop) ? TO : cfg_f[k]);

        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_rw     = rw;
        req_addr   = a;
        req_wdata  = wd;
        req_cs_sel = sel;
        to = 0;
        while (acc_q.size() == ba && to < 100) begin
            @(posedge clk);
            to++;
        end
        #1;
        req_valid = 1'b0;
        req_wdata = 8'($urandom);
        chk({tag, "_accept"}, acc_q.size() - ba, 1);
        to = 0;
        while (rsp_cyc_q.size() == br && to < 3 * TO + 500) begin
            @(posedge clk);
            to++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_rsp_count"}, rsp_cyc_q.size() - br, 1);
        chk({tag, "_nbytes"}, trig_q.size() - bt, nb);
        for (int k = 0; k < nb; k++)
            if (trig_q.size() > bt + k)
                chk($sformatf("%s_byte%0d", tag, k), trig_q[bt + k], exp_byte(rw, a, wd, k));
        if (rsp_cyc_q.size() > br && acc_q.size() > ba) begin
            chk({tag, "_rdata"}, rsp_rd_q[br], exp_rd);
            chk({tag, "_err"}, rsp_er_q[br], (drop >= 0) ? 1 : 0);
            chk({tag, "_latency"}, rsp_cyc_q[br] - acc_q[ba], lat);
            chk({tag, "_rdata_hold"}, rsp_rdata, exp_rd);
        end
        if (fall_cyc_q.size() > bfl && rise_cyc_q.size() > bri && trig_q.size() >= bt + nb
            && rsp_cyc_q.size() > br && acc_q.size() > ba) begin
            chk({tag, "_cs_sel"}, fall_val_q[bfl], exp_cs);
            chk({tag, "_cs_fall"}, fall_cyc_q[bfl] - acc_q[ba], 1);
            chk({tag, "_setup"}, trig_cyc_q[bt] - fall_cyc_q[bfl], S);
            chk({tag, "_rise_rsp"}, rise_cyc_q[bri] - rsp_cyc_q[br], 0);
            if (drop < 0) begin
                chk({tag, "_nfin"}, fin_cyc_q.size() - bf, 3);
                if (fin_cyc_q.size() > bf)
                    chk({tag, "_hold"}, rise_cyc_q[bri] - fin_cyc_q[fin_cyc_q.size() - 1], H + 1);
            end else begin
                chk({tag, "_timeout"}, rise_cyc_q[bri] - trig_cyc_q[bt + drop], TO + H + 1);
            end
        end
    endtask

    initial begin
        int ba, br, bt, r0, to, bs, bt2;
        logic [14:0] a1, a2;
        logic [7:0]  w1;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_trig", spi_trig, 0);
        chk("rst_wdata", spi_writedata, 0);
        chk("rst_cs", frame_cs_n, 4'hF);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release_ready", req_ready, 1);

        run_txn("t1_write", 1'b0, 15'h1234, 8'hA5, 2'd2, 8'($urandom),
                $urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(1, 5), -1);
        run_txn("t2_read", 1'b1, 15'h0010, 8'($urandom), 2'd0, 8'h5C,
                $urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(1, 5), -1);
        run_txn("t3_timeout", 1'b1, 15'($urandom), 8'($urandom), 2'd1, 8'h77, 2, 3, 3, 1);
        run_txn("t3_after", 1'b1, 15'($urandom), 8'($urandom), 2'd3, 8'hC3, 2, 1, 4, -1);

        // back-to-back with req_valid held high
        cfg_f    = '{3, 2, 1};
        cfg_drop = -1;
        cfg_rd   = 8'h3C;
        a1 = 15'($urandom);
        a2 = 15'($urandom);
        w1 = 8'($urandom);
        ba = acc_q.size();
        br = rsp_cyc_q.size();
        bt = trig_q.size();
        r0 = rdy_in_frame;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_rw = 1'b0; req_addr = a1; req_wdata = w1; req_cs_sel = 2'd1;
        to = 0;
        while (acc_q.size() == ba && to < 100) begin @(posedge clk); to++; end
        #1;
        req_rw = 1'b1; req_addr = a2; req_wdata = 8'($urandom); req_cs_sel = 2'd3;
        to = 0;
        while (acc_q.size() == ba + 1 && to < 200) begin @(posedge clk); to++; end
        #1;
        req_valid = 1'b0;
        to = 0;
        while (rsp_cyc_q.size() < br + 2 && to < 200) begin @(posedge clk); to++; end
        #1;
        chk("t4_accepts", acc_q.size() - ba, 2);
        chk("t4_rsps", rsp_cyc_q.size() - br, 2);
        chk("t4_ready_in_frame", rdy_in_frame - r0, 0);
        if (acc_q.size() >= ba + 2 && rsp_cyc_q.size() >= br + 2 && trig_q.size() >= bt + 6) begin
            chk("t4_gap", acc_q[ba + 1] - rsp_cyc_q[br], I + 1);
            chk("t4_rdata0", rsp_rd_q[br], 8'h00);
            chk("t4_rdata1", rsp_rd_q[br + 1], 8'h3C);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("t4_a_byte%0d", k), trig_q[bt + k], exp_byte(1'b0, a1, w1, k));
                chk($sformatf("t4_b_byte%0d", k), trig_q[bt + 3 + k], exp_byte(1'b1, a2, 8'h00, k));
            end
        end

        // reset during the wait for byte 1
        repeat (I + 3) @(posedge clk);
        cfg_f    = '{2, 5, 5};
        cfg_drop = 1;
        br = rsp_cyc_q.size();
        bt = trig_q.size();
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 15'($urandom); req_cs_sel = 2'd2;
        to = 0;
        while (trig_q.size() < bt + 2 && to < 100) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            to++;
        end
        repeat (2) @(posedge clk);
        #3;
        chk("t5_pre_cs", frame_cs_n, 4'hB);
        chk("t5_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_cs_async", frame_cs_n, 4'hF);
        chk("t5_trig_async", spi_trig, 0);
        chk("t5_busy_async", busy, 0);
        chk("t5_ready_async", req_ready, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_ready_after", req_ready, 1);
        repeat (30) @(posedge clk);
        #1;
        chk("t5_no_rsp", rsp_cyc_q.size() - br, 0);

        // finish on the last timeout cycle wins
        run_txn("t6_edge", 1'b1, 15'($urandom), 8'($urandom), 2'd1, 8'h96, 1, 2, TO, -1);

        // stray finish while idle
        repeat (I + 4) @(posedge clk);
        bs  = rsp_cyc_q.size();
        bt2 = trig_q.size();
        stray_cnt++;
        repeat (6) @(posedge clk);
        #1;
        chk("t6_stray_busy", busy, 0);
        chk("t6_stray_ready", req_ready, 1);
        chk("t6_stray_cs", frame_cs_n, 4'hF);
        chk("t6_stray_rsp", rsp_cyc_q.size() - bs, 0);
        chk("t6_stray_trig", trig_q.size() - bt2, 0);

        for (int n = 0; n < 8; n++)
            run_txn($sformatf("rand%0d", n), 1'($urandom), 15'($urandom), 8'($urandom),
                    2'($urandom), 8'($urandom), $urandom_range(1, 6),
                    $urandom_range(1, 6), $urandom_range(1, 6), -1);

        chk("one_cs_low", bad_cs, 0);
        chk("ready_in_frame", rdy_in_frame, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_frame_ctrl.md
Name: spi_frame_ctrl

Overview:
Frame-level sequencer that sits directly upstream of the byte-level SPI master in the acquisition FPGA. It accepts one register access request (read/write, 15-bit address, 8-bit data, device select) and splits it into a 3-byte SPI frame. It drives the byte master's trig/writedata, collects finish/readdata, and owns the per-device frame chip-select, held low across all three bytes. The byte master's own per-byte cs is left unused.

Parameters:
NUM_CS, 4, number of frame chip-select outputs; CS_SEL_W = clog2(NUM_CS)
CS_SETUP_CYC, 4, clk cycles from cs_n low to first spi_trig; legal range >= 1
CS_HOLD_CYC, 4, clk cycles from last spi_finish to cs_n high; legal range >= 1
CS_IDLE_CYC, 8, minimum clk cycles cs_n stays high before the next request is accepted; legal range >= 1
TIMEOUT_CYC, 4096, maximum clk cycles to wait for spi_finish per byte; legal range >= 2

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  request valid
req_ready  out  1  high only in IDLE
req_rw  in  1  1 = read, 0 = write
req_addr  in  15  register address
req_wdata  in  8  write data; ignored for reads
req_cs_sel  in  CS_SEL_W  target device index
rsp_valid  out  1  one-cycle pulse, transaction complete; no backpressure
rsp_rdata  out  8  read byte; 0 for writes and on error
rsp_err  out  1  timeout flag, valid with rsp_valid
busy  out  1  high whenever state != IDLE
spi_trig  out  1  one-cycle start pulse to byte master
spi_writedata  out  8  byte to transmit
spi_finish  in  1  byte-done pulse from byte master
spi_readdata  in  8  received byte, valid while spi_finish = 1
frame_cs_n  out  NUM_CS  active-low device selects

Behaviour:
- Reset values: req_ready=0 during reset, 1 on the first cycle after release. rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, spi_trig=0, spi_writedata=0, frame_cs_n=all 1s. Asserting rst_n mid-frame forces these values immediately (asynchronous).
- Frame bytes: B0 = {req_rw, req_addr[14:8]}, B1 = req_addr[7:0], B2 = req_wdata for a write, 0x00 for a read. Bytes are sent MSB-first. All request fields are captured on the accept edge.
- All outputs are registered.
- FSM states: IDLE, SETUP, TRIG, WAIT, HOLD, GAP. A byte index idx (0..2) and a shared down-counter support the FSM.
- IDLE: on req_valid && req_ready at edge T, capture the request, set idx=0, drive frame_cs_n[req_cs_sel]=0 from T+1, and go to SETUP. Only one cs_n bit is ever low.
- SETUP: lasts exactly CS_SETUP_CYC cycles, then TRIG.
- TRIG: one cycle. spi_trig=1 and spi_writedata=B[idx], both registered. spi_writedata holds until the next TRIG. Go to WAIT and load the timeout counter.
- WAIT:
  - On spi_finish with idx<2: idx++, go to TRIG. The next trig occurs the cycle after finish.
  - On spi_finish with idx==2: latch spi_readdata into the read register (reads only), go to HOLD.
  - If TIMEOUT_CYC cycles elapse with no finish: set the error flag, go to HOLD. Remaining bytes are abandoned.
  - spi_finish in the same cycle the timeout expires: finish wins and no error is flagged.
- spi_finish outside WAIT is ignored.
- HOLD: lasts CS_HOLD_CYC cycles, then frame_cs_n returns to all 1s. In that same cycle rsp_valid=1 with rsp_rdata/rsp_err. rsp_rdata=0 if write or error. Then go to GAP.
- rsp_rdata and rsp_err hold their values until the next rsp_valid.
- GAP: lasts CS_IDLE_CYC cycles with cs_n high, then IDLE.
- busy = !IDLE.
- A request presented while not ready is not captured and must be held by the requester.
- Total latency with a byte master taking F cycles per byte (trig to finish) is 1 + CS_SETUP_CYC + 3*(1+F) + CS_HOLD_CYC cycles, measured from accept edge to rsp_valid.

Test Plan:
1. Write, addr=0x1234, wdata=0xA5, sel=2, behavioural byte master: spi_writedata sequence 0x12, 0x34, 0xA5. Only frame_cs_n[2] is low, from T+1 through the end of HOLD. rsp_valid=1 once with rsp_rdata=0x00 and rsp_err=0.
2. Read, addr=0x0010, sel=0, slave returns 0x5C on byte 3: bytes sent are 0x80, 0x10, 0x00, and rsp_rdata=0x5C. Exactly 4 cycles separate cs_n falling from the first spi_trig, and 4 cycles separate the last spi_finish from cs_n rising.
3. Timeout: the model never returns finish on byte 1. After TIMEOUT_CYC cycles, cs_n rises CS_HOLD_CYC later, with rsp_err=1 and rsp_rdata=0. The next request still completes normally.
4. Back-to-back: req_valid held high for two requests. The second is accepted exactly CS_IDLE_CYC+1 cycles after the first rsp_valid, and req_ready=0 throughout the first frame.
5. Reset mid-frame: rst_n is pulled low during WAIT of byte 1. frame_cs_n goes to all 1s and spi_trig to 0 without waiting for a clock edge. After release, req_ready=1 and no rsp_valid is emitted.
6. Corner: spi_finish arrives in the exact cycle the timeout expires, giving rsp_err=0. A stray spi_finish pulse in IDLE causes no state change.
